// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NREGS x WIDTH register file, two combinational reads, one write.
// Optional macro REGFILE_2R1W_BYPASS_EN forwards the write data to matching reads.
module regfile_2r1w #(
   parameter int WIDTH = 8,
   parameter int NREGS = 8,
   localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr0,
   output logic [WIDTH-1:0] rdata0,
   input  logic [AW-1:0]    raddr1,
   output logic [WIDTH-1:0] rdata1
);

   logic [WIDTH-1:0] mem_q [NREGS];
   logic [WIDTH-1:0] mem_d [NREGS];
   logic [NREGS-1:0] we;
   logic             wr_hit;

   // Per-entry enables; an out-of-range address matches no entry.
   always_comb begin
      we = '0;
      for (int i = 0; i < NREGS; i++) begin
         we[i] = wen && (waddr == AW'(i));
      end
      wr_hit = |we;
   end

   // Next-state: enabled entry takes wdata, the rest hold.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         mem_d[i] = we[i] ? wdata : mem_q[i];
      end
   end

   // Storage with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   // Read port 0: stored value, zero when out of range.
   always_comb begin
      rdata0 = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (raddr0 == AW'(i)) rdata0 = mem_q[i];
      end
`ifdef REGFILE_2R1W_BYPASS_EN
      if (rst && wr_hit && (raddr0 == waddr)) rdata0 = wdata;
`endif
   end

   // Read port 1: same as port 0, independent address.
   always_comb begin
      rdata1 = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (raddr1 == AW'(i)) rdata1 = mem_q[i];
      end
`ifdef REGFILE_2R1W_BYPASS_EN
      if (rst && wr_hit && (raddr1 == waddr)) rdata1 = wdata;
`endif
   end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: checks an 8-entry and a 5-entry instance against a
// simple array model, plus directed literal expectations.
`timescale 1ns/100ps
module tb_regfile_2r1w;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wen = 1'b0;
   logic [2:0] waddr = '0;
   logic [7:0] wdata = '0;
   logic [2:0] raddr0 = '0;
   logic [2:0] raddr1 = '0;
   logic [7:0] r8_0, r8_1, r5_0, r5_1;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

`ifdef REGFILE_2R1W_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic [7:0] m8 [8];
   logic [7:0] m5 [5];

   always #5 clk = ~clk;

   regfile_2r1w #(.WIDTH(8), .NREGS(8)) d8 (
      .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr0(raddr0), .rdata0(r8_0), .raddr1(raddr1), .rdata1(r8_1)
   );

   regfile_2r1w #(.WIDTH(8), .NREGS(5)) d5 (
      .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr0(raddr0), .rdata0(r5_0), .raddr1(raddr1), .rdata1(r5_1)
   );

   // Model: clear on reset, otherwise store in-range writes.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) m8[i] = 8'h00;
         for (int i = 0; i < 5; i++) m5[i] = 8'h00;
      end else if (wen) begin
         m8[waddr] = wdata;
         if (waddr < 5) m5[waddr] = wdata;
      end
   end

   function automatic logic [7:0] exp8(input logic [2:0] a);
      if (BYP && rst && wen && a == waddr) return wdata;
      return m8[a];
   endfunction

   function automatic logic [7:0] exp5(input logic [2:0] a);
      if (BYP && rst && wen && waddr < 5 && a == waddr) return wdata;
      if (a < 5) return m5[a];
      return 8'h00;
   endfunction

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc d8 rd0", r8_0, exp8(raddr0));
         chk("cyc d8 rd1", r8_1, exp8(raddr1));
         chk("cyc d5 rd0", r5_0, exp5(raddr0));
         chk("cyc d5 rd1", r5_1, exp5(raddr1));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      wen = 1'b1;
      waddr = a;
      wdata = d;
      step();
      wen = 1'b0;
   endtask

   logic [7:0] e5;

   initial begin
      wen = 1'b1;
      waddr = 3'd3;
      wdata = 8'hAA;
      raddr0 = 3'd3;
      raddr1 = 3'd0;
      step();
      cmp_en = 1'b1;
      step();
      step();
      #1;
      chk("rst hold d8 rd0", r8_0, 8'h00);
      chk("rst hold d5 rd0", r5_0, 8'h00);
      chk("rst hold d8 rd1", r8_1, 8'h00);
      wen = 1'b0;
      rst = 1'b1;
      step();
      chk("post rst d8", r8_0, 8'h00);
      chk("post rst d5", r5_0, 8'h00);

      for (int i = 0; i < 8; i++) wr(3'(i), 8'h10 + 8'(i));
      for (int a = 0; a < 8; a++) begin
         raddr0 = 3'(a);
         raddr1 = 3'(7 - a);
         #1;
         chk("fill d8 rd0", r8_0, 8'h10 + 8'(a));
         chk("fill d8 rd1", r8_1, 8'h17 - 8'(a));
         e5 = (a < 5) ? 8'h10 + 8'(a) : 8'h00;
         chk("fill d5 rd0", r5_0, e5);
      end
      step();

      waddr = 3'd2;
      wdata = 8'hFF;
      raddr0 = 3'd2;
      repeat (4) step();
      chk("hold d8", r8_0, 8'h12);
      chk("hold d5", r5_0, 8'h12);
      waddr = 'x;
      wdata = 'x;
      repeat (2) step();
      chk("x hold d8", r8_0, 8'h12);

      wen = 1'b1;
      waddr = 3'd4;
      wdata = 8'h5A;
      raddr0 = 3'd4;
      raddr1 = 3'd4;
      #1;
      chk("rw same d8 rd0", r8_0, BYP ? 8'h5A : 8'h14);
      chk("rw same d8 rd1", r8_1, BYP ? 8'h5A : 8'h14);
      chk("rw same d5 rd0", r5_0, BYP ? 8'h5A : 8'h14);
      step();
      wen = 1'b0;
      chk("rw after d8 rd0", r8_0, 8'h5A);
      chk("rw after d8 rd1", r8_1, 8'h5A);
      chk("rw after d5 rd1", r5_1, 8'h5A);

      wr(3'd6, 8'h77);
      raddr0 = 3'd6;
      #1;
      chk("oor rd d5", r5_0, 8'h00);
      chk("oor wr d8", r8_0, 8'h77);
      for (int a = 0; a < 5; a++) begin
         raddr1 = 3'(a);
         #1;
         e5 = (a == 4) ? 8'h5A : 8'h10 + 8'(a);
         chk("oor keep d5", r5_1, e5);
      end
      step();

      raddr0 = 3'd1;
      raddr1 = 3'd4;
      #1;
      rst = 1'b0;
      #1;
      chk("async d8 rd0", r8_0, 8'h00);
      chk("async d8 rd1", r8_1, 8'h00);
      chk("async d5 rd1", r5_1, 8'h00);
      rst = 1'b1;
      step();
      for (int a = 0; a < 8; a++) begin
         raddr0 = 3'(a);
         #1;
         chk("async clr d8", r8_0, 8'h00);
      end
      step();
      wr(3'd1, 8'h33);
      raddr0 = 3'd1;
      raddr1 = 3'd0;
      #1;
      chk("post async d8", r8_0, 8'h33);
      chk("post async d5", r5_0, 8'h33);
      chk("post async d8 e0", r8_1, 8'h00);

      wen = 1'b1;
      waddr = 3'd1;
      wdata = 8'h41;
      step();
      wdata = 8'h42;
      step();
      wen = 1'b0;
      chk("b2b last wins", r8_0, 8'h42);
      step();

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
